// File: rtl/bcd_count_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bcd_count_sequencer
//  Purpose  : Three-digit BCD up/down counter (000-999) controlled by a switch
//             bank, with a software preload handshake and LED status.
//  Ports    :
//    clk_clk       in   system clock
//    reset_reset_n in   asynchronous active-low reset
//    sw[3:0]       in   raw switches: [0] run, [1] down, [2] clear, [3] fast
//    load_valid    in   preload request, held until load_ready is seen
//    load_data     in   preload value {hundreds, tens, units} in BCD
//    load_ready    out  preload accepted on the cycle where both are high
//    unites        out  units digit
//    dizaines      out  tens digit
//    centaines     out  hundreds digit
//    wrap          out  one-cycle pulse after a 999<->000 wrap
//    led[7:0]      out  {heartbeat, 00, load_err, wrap sticky, fast, down, counting}
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_count_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int FAST_DIV = 5000000,
    parameter int DIV_W    = 26
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [3:0]  sw,
    input  logic        load_valid,
    input  logic [11:0] load_data,
    output logic        load_ready,
    output logic [3:0]  unites,
    output logic [3:0]  dizaines,
    output logic [3:0]  centaines,
    output logic        wrap,
    output logic [7:0]  led
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_COUNT = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] C_SLOW_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] C_FAST_LAST = DIV_W'(FAST_DIV - 1);

    state_t             state_q,       state_d;
    logic [3:0]         sw_meta_q;
    logic [3:0]         sw_sync_q;
    logic [DIV_W-1:0]   presc_q,       presc_d;
    logic [3:0]         units_q,       units_d;
    logic [3:0]         tens_q,        tens_d;
    logic [3:0]         hund_q,        hund_d;
    logic               wrap_q,        wrap_d;
    logic               wrap_sticky_q, wrap_sticky_d;
    logic               load_err_q,    load_err_d;
    logic               hb_q,          hb_d;
    logic               load_ready_q,  load_ready_d;

    logic [DIV_W-1:0]   div_last;
    logic               tick;
    logic               accept;
    logic               load_ok;
    logic [3:0]         step_u, step_t, step_h;
    logic               step_wrap;
    logic               carry_u, carry_t;

    // Switches are asynchronous: two-flop synchronizer, decisions use sw_sync_q.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_meta_q <= 4'd0;
            sw_sync_q <= 4'd0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Next state: clear overrides everything, otherwise the run switch decides.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP:  if (sw_sync_q[0])  state_d = ST_COUNT;
            ST_COUNT: if (!sw_sync_q[0]) state_d = ST_STOP;
            ST_CLEAR: if (!sw_sync_q[2]) state_d = sw_sync_q[0] ? ST_COUNT : ST_STOP;
            default:  state_d = ST_STOP;
        endcase
        if (sw_sync_q[2]) state_d = ST_CLEAR;
    end

    // One BCD step in the selected direction, with ripple carry/borrow.
    always_comb begin
        step_u    = units_q;
        step_t    = tens_q;
        step_h    = hund_q;
        step_wrap = 1'b0;
        carry_u   = 1'b0;
        carry_t   = 1'b0;
        if (!sw_sync_q[1]) begin
            carry_u   = (units_q == 4'd9);
            carry_t   = carry_u && (tens_q == 4'd9);
            step_wrap = carry_t && (hund_q == 4'd9);
            step_u    = carry_u ? 4'd0 : units_q + 4'd1;
            if (carry_u) step_t = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            if (carry_t) step_h = (hund_q == 4'd9) ? 4'd0 : hund_q + 4'd1;
        end else begin
            carry_u   = (units_q == 4'd0);
            carry_t   = carry_u && (tens_q == 4'd0);
            step_wrap = carry_t && (hund_q == 4'd0);
            step_u    = carry_u ? 4'd9 : units_q - 4'd1;
            if (carry_u) step_t = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            if (carry_t) step_h = (hund_q == 4'd0) ? 4'd9 : hund_q - 4'd1;
        end
    end

    // Datapath: clear > valid load > tick. A rejected load does not block a tick.
    always_comb begin
        presc_d       = presc_q;
        units_d       = units_q;
        tens_d        = tens_q;
        hund_d        = hund_q;
        wrap_d        = 1'b0;
        wrap_sticky_d = wrap_sticky_q;
        load_err_d    = load_err_q;
        hb_d          = hb_q;

        div_last = sw_sync_q[3] ? C_FAST_LAST : C_SLOW_LAST;
        // ">=" rather than "==" so a slow-to-fast switch past the fast limit ticks at once.
        tick     = (state_q == ST_COUNT) && (presc_q >= div_last);
        accept   = load_valid && load_ready_q;
        load_ok  = (load_data[3:0] <= 4'd9) && (load_data[7:4] <= 4'd9) &&
                   (load_data[11:8] <= 4'd9);

        if (state_d == ST_CLEAR) begin
            presc_d       = '0;
            units_d       = 4'd0;
            tens_d        = 4'd0;
            hund_d        = 4'd0;
            wrap_sticky_d = 1'b0;
            load_err_d    = 1'b0;
        end else if (accept && load_ok) begin
            presc_d = '0;
            units_d = load_data[3:0];
            tens_d  = load_data[7:4];
            hund_d  = load_data[11:8];
        end else begin
            if (accept) load_err_d = 1'b1;
            if (tick) begin
                presc_d = '0;
                hb_d    = ~hb_q;
                units_d = step_u;
                tens_d  = step_t;
                hund_d  = step_h;
                wrap_d  = step_wrap;
                if (step_wrap) wrap_sticky_d = 1'b1;
            end else if (state_q == ST_COUNT) begin
                presc_d = presc_q + 1'b1;
            end
        end

        // Ready pulses for one cycle and then drops, so accepts are at least 2 cycles apart.
        // A request seen while clearing stays pending until clear is released.
        load_ready_d = load_valid && !load_ready_q && (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= ST_STOP;
            presc_q       <= '0;
            units_q       <= 4'd0;
            tens_q        <= 4'd0;
            hund_q        <= 4'd0;
            wrap_q        <= 1'b0;
            wrap_sticky_q <= 1'b0;
            load_err_q    <= 1'b0;
            hb_q          <= 1'b0;
            load_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            units_q       <= units_d;
            tens_q        <= tens_d;
            hund_q        <= hund_d;
            wrap_q        <= wrap_d;
            wrap_sticky_q <= wrap_sticky_d;
            load_err_q    <= load_err_d;
            hb_q          <= hb_d;
            load_ready_q  <= load_ready_d;
        end
    end

    assign unites     = units_q;
    assign dizaines   = tens_q;
    assign centaines  = hund_q;
    assign wrap       = wrap_q;
    assign load_ready = load_ready_q;
    assign led        = {hb_q, 2'b00, load_err_q, wrap_sticky_q,
                         sw_sync_q[3], sw_sync_q[1], (state_q == ST_COUNT)};

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_count_sequencer
//  Purpose  : Scoreboard bench for bcd_count_sequencer. A reference model keeps
//             the count as an integer 0..999 and pushes the expected outputs
//             every clock; a monitor pops and compares on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_count_sequencer;

    localparam int TICK = 4;
    localparam int FAST = 2;
    localparam int M_STOP  = 0;
    localparam int M_COUNT = 1;
    localparam int M_CLEAR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sw = 4'd0;
    logic        load_valid = 1'b0;
    logic [11:0] load_data = 12'd0;
    logic        load_ready;
    logic [3:0]  unites, dizaines, centaines;
    logic        wrap;
    logic [7:0]  led;

    int vectors = 0;
    int miscompares = 0;
    int cycle_no = 0;

    bcd_count_sequencer #(.TICK_DIV(TICK), .FAST_DIV(FAST), .DIV_W(3)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sw            (sw),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .unites        (unites),
        .dizaines      (dizaines),
        .centaines     (centaines),
        .wrap          (wrap),
        .led           (led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] dig;
        logic        wr;
        logic [7:0]  led;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    logic [3:0] m_meta = 4'd0;
    logic [3:0] m_ssw  = 4'd0;
    int         m_mode = M_STOP;
    int         m_presc = 0;
    int         m_n = 0;
    bit         m_wst = 0, m_est = 0, m_hb = 0, m_rdy = 0;

    function automatic logic [11:0] to_bcd(input int n);
        logic [3:0] h, t, u;
        h = 4'(n / 100);
        t = 4'((n / 10) % 10);
        u = 4'(n % 10);
        return {h, t, u};
    endfunction

    function automatic bit bcd_ok(input logic [11:0] d);
        return (d[11:8] < 4'd10) && (d[7:4] < 4'd10) && (d[3:0] < 4'd10);
    endfunction

    function automatic int bcd_val(input logic [11:0] d);
        return int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    task automatic model_reset();
        m_meta = 4'd0; m_ssw = 4'd0; m_mode = M_STOP; m_presc = 0; m_n = 0;
        m_wst = 0; m_est = 0; m_hb = 0; m_rdy = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int   nmode, div;
        bit   accept, nw;
        exp_t e;
        nmode  = m_ssw[2] ? M_CLEAR : (m_ssw[0] ? M_COUNT : M_STOP);
        accept = load_valid && m_rdy;
        nw     = 0;
        if (nmode == M_CLEAR) begin
            m_n = 0; m_presc = 0; m_wst = 0; m_est = 0;
        end else if (accept && bcd_ok(load_data)) begin
            m_n = bcd_val(load_data); m_presc = 0;
        end else begin
            if (accept) m_est = 1;
            if (m_mode == M_COUNT) begin
                div = m_ssw[3] ? FAST : TICK;
                if (m_presc >= div - 1) begin
                    m_presc = 0;
                    m_hb = !m_hb;
                    if (m_ssw[1]) begin
                        nw = (m_n == 0);
                        m_n = (m_n + 999) % 1000;
                    end else begin
                        nw = (m_n == 999);
                        m_n = (m_n + 1) % 1000;
                    end
                    if (nw) m_wst = 1;
                end else begin
                    m_presc++;
                end
            end
        end
        m_rdy  = load_valid && !m_rdy && (nmode != M_CLEAR);
        m_mode = nmode;
        m_ssw  = m_meta;
        m_meta = sw;
        e.dig = to_bcd(m_n);
        e.wr  = nw;
        e.led = {m_hb, 2'b00, m_est, m_wst, m_ssw[3], m_ssw[1], (m_mode == M_COUNT)};
        e.rdy = m_rdy;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {centaines, dizaines, unites, wrap, led, load_ready};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle %0d: got dig=%03h wrap=%b led=%08b rdy=%b, expected dig=%03h wrap=%b led=%08b rdy=%b",
                             cycle_no, a.dig, a.wr, a.led, a.rdy, e.dig, e.wr, e.led, e.rdy);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_unites"},    {8'd0, unites},    12'd0);
        chk({tag, "_dizaines"},  {8'd0, dizaines},  12'd0);
        chk({tag, "_centaines"}, {8'd0, centaines}, 12'd0);
        chk({tag, "_wrap"},      {11'd0, wrap},     12'd0);
        chk({tag, "_led"},       {4'd0, led},       12'd0);
        chk({tag, "_ready"},     {11'd0, load_ready}, 12'd0);
    endtask

    // Issue a preload and hold it until the handshake completes (bounded).
    task automatic do_load(input logic [11:0] v, input int maxw);
        bit got;
        got = 0;
        load_valid = 1'b1;
        load_data  = v;
        for (int i = 0; i < maxw && !got; i++) begin
            @(negedge clk);
            if (load_ready) got = 1;
        end
        if (got) begin
            @(negedge clk);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout: got no load_ready within %0d cycles, expected one", maxw);
        end
        load_valid = 1'b0;
    endtask

    // Reset asserted between edges must clear outputs without a clock edge.
    task automatic async_reset_check(input string tag);
        @(negedge clk);
        load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        cyc(3);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  nsw;
        logic [11:0] d;
        int          r, n;

        sw = 4'b0001;
        cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Free-running up count from reset.
        cyc(20);

        // Up through 999 -> 000 with wrap, then clear pulse drops the sticky.
        do_load(12'h998, 40);
        cyc(12);
        sw = 4'b0101; cyc(5);
        sw = 4'b0011;                     // down from 000
        cyc(14);

        // Rejected preload, then valid preloads at every prescaler phase.
        sw = 4'b0001;
        do_load(12'h1A3, 40);
        cyc(3);
        for (int ph = 0; ph < 4; ph++) begin
            cyc(ph + 1);
            do_load(12'h123, 40);
        end
        cyc(6);

        // Clear while a preload is pending.
        do_load(12'h456, 40);
        cyc(2);
        fork
            begin sw = 4'b0101; cyc(10); sw = 4'b0001; end
            begin cyc(3); do_load(12'h321, 40); end
        join
        cyc(8);

        // Slow-to-fast switch at different phases, fast down count, then reset.
        for (int ph = 0; ph < 4; ph++) begin
            sw = 4'b0001; cyc(ph + 4);
            sw = 4'b1001; cyc(7);
        end
        sw = 4'b1011; cyc(9);
        sw = 4'b0000; cyc(4);
        sw = 4'b0001; cyc(6);
        async_reset_check("async_rst1");
        cyc(10);

        // Randomized traffic.
        for (int k = 0; k < 160; k++) begin
            if (k == 60 || k == 120) async_reset_check("async_rst_rand");
            r = int'($urandom_range(0, 99));
            if (r < 30) begin
                cyc(int'($urandom_range(1, 8)));
            end else if (r < 55) begin
                nsw[0] = ($urandom_range(0, 9) < 8);
                nsw[1] = 1'($urandom_range(0, 1));
                nsw[2] = 1'b0;
                nsw[3] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) begin
                    sw = nsw | 4'b0100;
                    cyc(int'($urandom_range(1, 5)));
                end
                sw = nsw;
                cyc(int'($urandom_range(1, 4)));
            end else begin
                case ($urandom_range(0, 4))
                    0: begin
                        n = int'($urandom_range(0, 3));
                        n = (n == 0) ? 998 : (n == 1) ? 999 : (n == 2) ? 0 : 1;
                        d = to_bcd(n);
                    end
                    1: d = 12'($urandom);
                    default: begin
                        n = int'($urandom_range(0, 999));
                        d = to_bcd(n);
                    end
                endcase
                cyc(int'($urandom_range(0, 3)));
                do_load(d, 40);
            end
        end

        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
